// File: rtl/mux_3to1.sv
// rtl/mux_3to1.sv - 3:1 next-PC select mux with illegal-select flagging
// Optional output register compiled in by defining MUX_3TO1_REG_OUT_EN.

module mux_3to1 #(
  parameter int WIDTH            = 32,
  parameter int ILLEGAL_SEL_ZERO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             sel_err,
  output logic             sel_err_sticky
);

  logic [WIDTH-1:0] mux_val;

  // Code 2'b11 is never decoded as a real path; it falls back to the
  // sequential path or to zero depending on ILLEGAL_SEL_ZERO.
  always_comb begin
    mux_val = in0;
    case (sel)
      2'b00: mux_val = in0;
      2'b01: mux_val = in1;
      2'b10: mux_val = in2;
      2'b11: mux_val = (ILLEGAL_SEL_ZERO != 0) ? '0 : in0;
    endcase
  end

  assign sel_err = (sel == 2'b11);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_sticky <= 1'b0;
    end else if (sel_err) begin
      sel_err_sticky <= 1'b1;
    end
  end

`ifdef MUX_3TO1_REG_OUT_EN
  logic [WIDTH-1:0] out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= mux_val;
    end
  end

  assign out = out_q;
`else
  assign out = mux_val;
`endif

endmodule

// File: tb/tb_mux_3to1.sv
// tb/tb_mux_3to1.sv - scoreboard bench for mux_3to1 (both MUX_3TO1_REG_OUT_EN builds)

module tb_mux_3to1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in0 = '0, in1 = '0, in2 = '0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] out_a, out_z;
  logic        err_a, err_z, stk_a, stk_z;

  logic [7:0]  in0_8 = '0, in1_8 = '0, in2_8 = '0;
  logic [1:0]  sel8 = 2'b00;
  logic [7:0]  out_8;
  logic        err_8, stk_8;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  mux_3to1 #(.WIDTH(32), .ILLEGAL_SEL_ZERO(0)) dut (
    .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .sel(sel),
    .out(out_a), .sel_err(err_a), .sel_err_sticky(stk_a)
  );

  mux_3to1 #(.WIDTH(32), .ILLEGAL_SEL_ZERO(1)) dut_z (
    .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .sel(sel),
    .out(out_z), .sel_err(err_z), .sel_err_sticky(stk_z)
  );

  mux_3to1 #(.WIDTH(8), .ILLEGAL_SEL_ZERO(0)) dut8 (
    .clk(clk), .rst(rst), .in0(in0_8), .in1(in1_8), .in2(in2_8), .sel(sel8),
    .out(out_8), .sel_err(err_8), .sel_err_sticky(stk_8)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    sb_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL sb_empty: observed %h expected queued entry", obs);
    end else begin
      e = sb_q.pop_front();
      cmp(e.tag, obs, e.exp);
    end
  endtask

  // Wait until the output reflects freshly driven inputs.
  task automatic settle();
`ifdef MUX_3TO1_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  initial begin
    logic [31:0] r0, r1, r2;
    logic [7:0]  a8, b8;

    // Reset state
    #1 rst = 1'b1;
    #1;
    cmp("rst_sticky", {31'd0, stk_a}, 32'd0);
    cmp("rst_sel_err", {31'd0, err_a}, 32'd0);
    sb_push("rst_out", 32'h0);
    sb_check(out_a);
    sb_push("rst_out8", 32'h0);
    sb_check({24'd0, out_8});

    @(negedge clk);
    rst = 1'b0;

    // Legal codes with small next-PC values
    in0 = 32'h0000_0004;
    in1 = 32'h0000_0100;
    in2 = 32'h0000_0200;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      sel = s[1:0];
      sb_push($sformatf("sel%0d_out", s), (s == 0) ? in0 : (s == 1) ? in1 : in2);
      settle();
      sb_check(out_a);
      cmp($sformatf("sel%0d_err", s), {31'd0, err_a}, 32'd0);
    end

    // Illegal code: fallback to in0 vs zero, sticky sets on the edge
    @(negedge clk);
    in0 = 32'h0123_4567;
    sel = 2'b11;
    #1;
    cmp("ill_err", {31'd0, err_a}, 32'd1);
    cmp("ill_sticky_pre", {31'd0, stk_a}, 32'd0);
    sb_push("ill_out_in0", 32'h0123_4567);
    sb_push("ill_out_zero", 32'h0);
    @(posedge clk);
    #1;
    sb_check(out_a);
    sb_check(out_z);
    cmp("ill_sticky_post", {31'd0, stk_a}, 32'd1);

    @(negedge clk);
    in0 = 32'hFFFF_FFFF;
    sb_push("ill_ones_in0", 32'hFFFF_FFFF);
    sb_push("ill_ones_zero", 32'h0);
    settle();
    sb_check(out_a);
    sb_check(out_z);
    cmp("ill_err_z", {31'd0, err_z}, 32'd1);

    @(negedge clk);
    sel = 2'b00;
    #1;
    cmp("legal_err", {31'd0, err_a}, 32'd0);
    sb_push("back0_out", 32'hFFFF_FFFF);
    sb_push("back0_out_z", 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    sb_check(out_a);
    sb_check(out_z);
    cmp("sticky_hold", {31'd0, stk_a}, 32'd1);

    // Mid-cycle change on the branch path
    @(negedge clk);
    sel = 2'b10;
    in2 = 32'h89AB_CDEF;
    #1;
`ifdef MUX_3TO1_REG_OUT_EN
    sb_push("mid_hold", 32'hFFFF_FFFF);
`else
    sb_push("mid_hold", 32'h89AB_CDEF);
`endif
    sb_check(out_a);
    sb_push("mid_edge", 32'h89AB_CDEF);
    @(posedge clk);
    #1;
    sb_check(out_a);

    // Asynchronous reset between edges, then held across an edge
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("arst_sticky", {31'd0, stk_a}, 32'd0);
`ifdef MUX_3TO1_REG_OUT_EN
    sb_push("arst_out", 32'h0);
`else
    sb_push("arst_out", 32'h89AB_CDEF);
`endif
    sb_check(out_a);
    sel = 2'b11;
    in2 = 32'h1111_1111;
    @(posedge clk);
    #1;
    cmp("rst_hold_sticky", {31'd0, stk_a}, 32'd0);
    cmp("rst_hold_err", {31'd0, err_a}, 32'd1);
`ifdef MUX_3TO1_REG_OUT_EN
    sb_push("rst_hold_out", 32'h0);
`else
    sb_push("rst_hold_out", 32'hFFFF_FFFF);
`endif
    sb_check(out_a);

    @(negedge clk);
    sel = 2'b10;
    in2 = 32'h89AB_CDEF;
    rst = 1'b0;
    #1;
`ifdef MUX_3TO1_REG_OUT_EN
    sb_push("rel_pre", 32'h0);
`else
    sb_push("rel_pre", 32'h89AB_CDEF);
`endif
    sb_check(out_a);
    sb_push("rel_edge", 32'h89AB_CDEF);
    @(posedge clk);
    #1;
    sb_check(out_a);
    cmp("rel_sticky", {31'd0, stk_a}, 32'd0);

    // Full-width patterns, non-selected inputs toggling
    for (int i = 0; i < 6; i++) begin
      r0 = $urandom();
      r1 = $urandom();
      r2 = $urandom();
      @(negedge clk);
      in0 = r0;
      in1 = r1;
      in2 = r2;
      sel = 2'b01;
      sb_push($sformatf("wide_in1_%0d", i), r1);
      settle();
      sb_check(out_a);
    end
    @(negedge clk);
    in0 = 32'h8000_0001;
    sel = 2'b00;
    sb_push("wide_in0_msb_lsb", 32'h8000_0001);
    settle();
    sb_check(out_a);

    // 8-bit instance: in1 held, others random
    @(negedge clk);
    in1_8 = 8'hA5;
    sel8  = 2'b01;
    for (int i = 0; i < 8; i++) begin
      a8 = 8'($urandom());
      b8 = 8'($urandom());
      @(negedge clk);
      in0_8 = a8;
      in2_8 = b8;
      sb_push($sformatf("w8_const_%0d", i), 32'h0000_00A5);
      settle();
      sb_check({24'd0, out_8});
    end
    cmp("w8_err", {31'd0, err_8}, 32'd0);
    cmp("w8_sticky", {31'd0, stk_8}, 32'd0);

    cmp("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
